// File: rtl/ssd1306_pkg.sv
// ============================================================================
// Module   : ssd1306_pkg
// Brief    : Shared types and constants for the SSD1306 procedure scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd1306_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } sched_state_t;

  // Requester indices for the default four-requester configuration.
  localparam int REQ_INIT     = 0;
  localparam int REQ_DISPLAY  = 1;
  localparam int REQ_CONTRAST = 2;
  localparam int REQ_REFRESH  = 3;

  localparam int          NUM_REQ_DEFAULT        = 4;
  localparam int          MICROCODE_SIZE_DEFAULT = 48;
  localparam logic [23:0] REFRESH_PERIOD_DEFAULT = 24'd1_000_000;

  // Refresh always occupies the highest requester slot.
  function automatic int refresh_index(input int num_req);
    return num_req - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd1306_prio_arbiter.sv
// ============================================================================
// Module   : ssd1306_prio_arbiter
// Brief    : Combinational fixed-priority arbiter, lowest index wins;
//            produces a one-hot grant, its index and a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd1306_prio_arbiter #(
  parameter  int unsigned N        = 4,
  localparam int unsigned IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        i_req,
  output logic [N-1:0]        o_grant,
  output logic [IDX_BITS-1:0] o_grant_idx,
  output logic                o_grant_valid
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant       = '0;
        o_grant[i]    = 1'b1;
        o_grant_idx   = IDX_BITS'(i);
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssd1306_procedure_scheduler.sv
// ============================================================================
// Module   : ssd1306_procedure_scheduler
// Brief    : Arbitrates SSD1306 procedure requests and hands one offset at a
//            time to the microcode executor. Optional macro
//            SSD1306_AUTO_REFRESH_EN adds a periodic refresh request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd1306_procedure_scheduler
  import ssd1306_pkg::*;
#(
  parameter  int unsigned MICROCODE_SIZE = MICROCODE_SIZE_DEFAULT,
  parameter  int unsigned NUM_REQ        = NUM_REQ_DEFAULT,
  parameter  int unsigned REFRESH_PERIOD = 32'(REFRESH_PERIOD_DEFAULT),
  localparam int unsigned ADDR_BITS      = $clog2(MICROCODE_SIZE),
  localparam int unsigned ID_BITS        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic [NUM_REQ-1:0]           req_in,
  input  logic [NUM_REQ*ADDR_BITS-1:0] offset_tbl_in,
  output logic [NUM_REQ-1:0]           ack_out,
  output logic [ADDR_BITS-1:0]         procedure_offset_out,
  output logic                         procedure_start_out,
  input  logic                         procedure_done_in,
  output logic [ID_BITS-1:0]           active_id_out,
  output logic                         busy_out,
  output logic                         init_done_out
);

  localparam logic [NUM_REQ-1:0] c_init_bit    = NUM_REQ'(1) << REQ_INIT;
  localparam logic [NUM_REQ-1:0] c_refresh_bit = NUM_REQ'(1) << refresh_index(NUM_REQ);

  sched_state_t         r_state;
  sched_state_t         w_state_next;
  logic [NUM_REQ-1:0]   r_pending;
  logic [NUM_REQ-1:0]   w_mask;
  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_grant_onehot;
  logic [ID_BITS-1:0]   w_grant_idx;
  logic                 w_grant_valid;
  logic                 w_grant_take;
  logic [NUM_REQ-1:0]   w_refresh_set;
  logic [ADDR_BITS-1:0] r_offset;
  logic [ID_BITS-1:0]   r_active_id;
  logic                 r_init_done;
  logic                 w_start;
  logic                 w_done_evt;
  logic [NUM_REQ-1:0]   w_ack_vec;
  logic [ADDR_BITS-1:0] w_offset_tbl [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tbl_slice
    assign w_offset_tbl[gi] = offset_tbl_in[gi*ADDR_BITS +: ADDR_BITS];
  end

  // Until init has completed only the init requester may be granted.
  assign w_mask     = r_init_done ? '1 : c_init_bit;
  assign w_eligible = r_pending & w_mask;

  ssd1306_prio_arbiter #(
    .N (NUM_REQ)
  ) u_arbiter (
    .i_req         (w_eligible),
    .o_grant       (w_grant_onehot),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign w_grant_take = (r_state == S_IDLE) && w_grant_valid;

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant_take)       w_state_next = S_ISSUE;
      S_ISSUE:     if (!procedure_done_in) w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY:                         w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (procedure_done_in)  w_state_next = S_IDLE;
      default:                             w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_start    = 1'b0;
    w_done_evt = 1'b0;
    w_ack_vec  = '0;
    case (r_state)
      S_ISSUE:     w_start    = 1'b1;
      S_WAIT_DONE: w_done_evt = procedure_done_in;
      default:     ;
    endcase
    if (w_done_evt) begin
      w_ack_vec = NUM_REQ'(1) << r_active_id;
    end
  end

  // Grant bookkeeping; a new request in the grant cycle re-pends the winner.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_pending   <= c_init_bit;
      r_offset    <= '0;
      r_active_id <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~(w_grant_take ? w_grant_onehot : '0))
                   | req_in | w_refresh_set;
      if (w_grant_take) begin
        r_active_id <= w_grant_idx;
        r_offset    <= w_offset_tbl[w_grant_idx];
      end
      if (w_done_evt && (r_active_id == ID_BITS'(REQ_INIT))) begin
        r_init_done <= 1'b1;
      end
    end
  end

`ifdef SSD1306_AUTO_REFRESH_EN
  localparam int unsigned CNT_BITS = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CNT_BITS-1:0] c_cnt_last = CNT_BITS'(REFRESH_PERIOD - 1);

  logic [CNT_BITS-1:0] r_refresh_cnt;
  logic                w_refresh_hit;

  assign w_refresh_hit = r_init_done && (r_refresh_cnt == c_cnt_last);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_refresh_cnt <= '0;
    end else if (r_init_done) begin
      r_refresh_cnt <= w_refresh_hit ? '0 : r_refresh_cnt + 1'b1;
    end
  end

  // Merges into an already-pending refresh through the OR above.
  assign w_refresh_set = w_refresh_hit ? c_refresh_bit : '0;
`else
  assign w_refresh_set = '0;
`endif

  assign ack_out              = w_ack_vec;
  assign procedure_start_out  = w_start;
  assign procedure_offset_out = r_offset;
  assign active_id_out        = r_active_id;
  assign busy_out             = (r_state != S_IDLE);
  assign init_done_out        = r_init_done;

endmodule

`default_nettype wire

// File: doc/ssd1306_procedure_scheduler.md
SSD1306_PROCEDURE_SCHEDULER -- requirements
Module: ssd1306_procedure_scheduler

Interface
REQ-001 SHALL have parameter MICROCODE_SIZE, default 48, microcode depth; ADDR_BITS = $clog2(MICROCODE_SIZE) is derived and is not overridable.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters; index 0 = init, index NUM_REQ-1 = refresh.
REQ-003 SHALL have parameter REFRESH_PERIOD, default 24'd1_000_000, clock cycles between automatic refresh requests.
REQ-004 SHALL have ports:
- clk_in  in  1  clock; all logic on posedge.
- reset_in  in  1  synchronous, active-high reset.
- req_in  in  NUM_REQ  request pulses or levels, one bit per requester.
- offset_tbl_in  in  NUM_REQ*ADDR_BITS  procedure offset per requester; slice i is [i*ADDR_BITS +: ADDR_BITS].
- ack_out  out  NUM_REQ  one-cycle pulse when requester i's procedure completes.
- procedure_offset_out  out  ADDR_BITS  offset presented to the executor.
- procedure_start_out  out  1  start request to the executor.
- procedure_done_in  in  1  executor idle/done level.
- active_id_out  out  $clog2(NUM_REQ)  index of the granted requester.
- busy_out  out  1  1 whenever state != S_IDLE.
- init_done_out  out  1  sticky; set when the init procedure completes.

Function
REQ-005 SHALL keep a pending bit per requester, set on any cycle req_in[i]=1 and cleared on grant; if a set and a clear hit the same cycle, the set wins.
REQ-006 SHALL mask pending bits 1..NUM_REQ-1 from arbitration while init_done_out=0; the masked bits stay latched.
REQ-007 SHALL use fixed-priority arbitration among the unmasked pending bits, lowest index wins, evaluated only in S_IDLE.
REQ-008 SHALL implement states S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE.
REQ-009 S_IDLE: when any unmasked bit is pending, SHALL latch the winner into active_id_out, latch its offset into procedure_offset_out, clear its pending bit, and go to S_ISSUE on the next cycle.
REQ-010 S_ISSUE: SHALL drive procedure_start_out=1 and go to S_WAIT_BUSY when procedure_done_in=0; otherwise it stays in S_ISSUE, and start stays high.
REQ-011 S_WAIT_BUSY: SHALL drive procedure_start_out=0 and go to S_WAIT_DONE on the next cycle.
REQ-012 S_WAIT_DONE: when procedure_done_in=1, SHALL pulse ack_out[active_id_out] for one cycle and return to S_IDLE.
REQ-013 Completion of requester 0 SHALL also set init_done_out=1.
REQ-014 procedure_start_out SHALL be 1 only in S_ISSUE.
REQ-015 procedure_offset_out SHALL hold its value from grant until the next grant.
REQ-016 Minimum spacing between two grants SHALL be 4 cycles: grant, issue, busy, done.
REQ-017 ack_out SHALL have at most one bit set in any cycle.

Reset
REQ-018 On reset_in=1 the block SHALL set: state S_IDLE; ack_out=0; procedure_start_out=0; procedure_offset_out=0; active_id_out=0; init_done_out=0; all pending bits 0 except pending[0]=1, so init is auto-requested; refresh counter 0.
REQ-019 Reset in the middle of an operation SHALL abandon that operation without any ack; init is re-pended through REQ-018.

Configuration
REQ-020 With SSD1306_AUTO_REFRESH_EN defined, SHALL include the refresh counter:
- The counter runs only while init_done_out=1.
- At REFRESH_PERIOD-1 it sets pending[NUM_REQ-1] and wraps to 0.
- If that bit is already pending, the request is merged and nothing further happens.
REQ-021 Without SSD1306_AUTO_REFRESH_EN, SHALL have no counter logic; refresh happens only through req_in[NUM_REQ-1].

Structure
REQ-022 SHALL take the following from package ssd1306_pkg:
- state enum sched_state_t;
- REQ_INIT=0 and the requester index constants;
- REFRESH_PERIOD_DEFAULT.
REQ-023 SHALL contain one sub-module, ssd1306_prio_arbiter: combinational lowest-index-first grant, producing a one-hot output plus an index.

Verification
REQ-024 Reset released, executor model takes done low after 2 cycles and high after 10 -> start high at cycle 1, offset=offset_tbl[0], ack_out=4'b0001 once, init_done_out=1.
REQ-025 req_in=4'b0110 pulsed for one cycle before init completes -> no grant until the init ack; then grant 1, then grant 2, each acked in order.
REQ-026 Executor holds done=1 for 5 cycles after start -> start stays high 5+ cycles, and no duplicate grant occurs.
REQ-027 With SSD1306_AUTO_REFRESH_EN defined and REFRESH_PERIOD=16 -> refresh granted every 16 cycles while idle; ack_out[3] pulses each time.
REQ-028 reset_in asserted during S_WAIT_DONE of requester 2 -> no ack_out[2]; after release, init re-runs first.
REQ-029 req_in[1] held at 1 across its own grant -> re-pended; a second procedure runs immediately after the first ack.
